// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: 32 x XLEN integer register file with per-register
// pending-write scoreboard. Writeback commits values and retires pending
// writes; issue registers new pending writes; decode reads data and busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through on the read
// ports and busy masking when the last pending write retires this cycle.
module wb_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int PEND_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_valid,
   input  logic            iss_we,
   input  logic [4:0]      iss_rd,
   output logic            iss_ready,
   input  logic            flush
);

   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [XLEN-1:0]   regs     [32];
   logic [PEND_W-1:0] cnt      [32];
   logic [PEND_W-1:0] cnt_next [32];
   logic [31:0]       inc_hit;
   logic [31:0]       dec_hit;
   logic              inc;
   logic              dec;

   // Issue may proceed unless the destination counter is already full
   assign iss_ready = (iss_rd == 5'd0) | (cnt[iss_rd] != CNT_MAX);
   assign inc       = iss_valid & iss_we & iss_ready & (iss_rd != 5'd0);
   assign dec       = wb_we & (wb_rd != 5'd0);

   // One-hot decode of which counter sees an issue and which sees a writeback
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_hit
         assign inc_hit[gi] = inc & (iss_rd == 5'(gi));
         assign dec_hit[gi] = dec & (wb_rd == 5'(gi));
      end
   endgenerate

   // Commit writeback data; x0 is never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (dec) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Next counter values: flush wins, matched inc/dec cancel, no underflow
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         cnt_next[i] = cnt[i];
         if (flush) begin
            cnt_next[i] = '0;
         end else if (inc_hit[i] && !dec_hit[i]) begin
            cnt_next[i] = cnt[i] + CNT_ONE;
         end else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0) begin
            cnt_next[i] = cnt[i] - CNT_ONE;
         end
      end
   end

   // Scoreboard counter state; entry 0 is held at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) cnt[i] <= '0;
      end else begin
         for (int i = 1; i < 32; i++) cnt[i] <= cnt_next[i];
         cnt[0] <= '0;
      end
   end

   // Read ports and busy flags
   always_comb begin
      rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
      rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
      rs1_busy = (cnt[rs1_addr] != '0);
      rs2_busy = (cnt[rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
      if (dec && wb_rd == rs1_addr) begin
         rs1_data = wb_data;
         if (cnt[rs1_addr] == CNT_ONE) rs1_busy = 1'b0;
      end
      if (dec && wb_rd == rs2_addr) begin
         rs2_data = wb_data;
         if (cnt[rs2_addr] == CNT_ONE) rs2_busy = 1'b0;
      end
`endif
   end

`ifndef SYNTHESIS
   // A writeback must always retire a previously issued write
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(dec && cnt[wb_rd] == '0));
`endif

endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb_wb_regfile_sb: directed test of wb_regfile_sb (reset, x0, RAW
// scoreboard, simultaneous inc/dec, saturation, flush).
module tb_wb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1_addr = '0, rs2_addr = '0;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        iss_valid = 1'b0, iss_we = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic        iss_ready;
   logic        flush = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   wb_regfile_sb #(.XLEN(32), .PEND_W(2)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
      .iss_ready(iss_ready), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1'b1; iss_we = 1'b1; iss_rd = rd;
      tick();
      iss_valid = 1'b0; iss_we = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      wb_we = 1'b1; wb_rd = rd; wb_data = d;
      tick();
      wb_we = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      rs1_addr = 5; rs2_addr = 31; iss_rd = 5; #1;
      check("rst_rs1_data", rs1_data, 32'h0);
      check("rst_rs1_busy", 32'(rs1_busy), 32'h0);
      check("rst_rs2_busy", 32'(rs2_busy), 32'h0);
      check("rst_iss_ready", 32'(iss_ready), 32'h1);

      // Async reset mid-cycle after writing x5
      issue(5); issue(5);
      wb(5, 32'hDEADBEEF);
      rs1_addr = 5; #1;
      check("x5_written", rs1_data, 32'hDEADBEEF);
      check("x5_busy_pre", 32'(rs1_busy), 32'h1);
      #1 rst = 1'b1; #1;
      check("async_rst_data", rs1_data, 32'h0);
      check("async_rst_busy", 32'(rs1_busy), 32'h0);
      iss_rd = 5; #1;
      check("async_rst_ready", 32'(iss_ready), 32'h1);
      rst = 1'b0;
      tick();

      // x0 handling
      wb(0, 32'h12345678);
      rs1_addr = 0; #1;
      check("x0_read", rs1_data, 32'h0);
      issue(0);
      check("x0_busy", 32'(rs1_busy), 32'h0);
      iss_rd = 0; #1;
      check("x0_ready", 32'(iss_ready), 32'h1);

      // RAW scoreboard on x7
      issue(7);
      rs1_addr = 7; #1;
      check("raw_busy_c1", 32'(rs1_busy), 32'h1);
      tick(); tick();
      wb_we = 1'b1; wb_rd = 7; wb_data = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
      check("raw_busy_c3", 32'(rs1_busy), 32'h0);
      check("raw_data_c3", rs1_data, 32'hA5A5A5A5);
`else
      check("raw_busy_c3", 32'(rs1_busy), 32'h1);
      check("raw_data_c3", rs1_data, 32'h0);
`endif
      tick();
      wb_we = 1'b0; #1;
      check("raw_busy_c4", 32'(rs1_busy), 32'h0);
      check("raw_data_c4", rs1_data, 32'hA5A5A5A5);

      // Simultaneous inc and dec on x9
      issue(9);
      iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 9;
      wb_we = 1'b1; wb_rd = 9; wb_data = 32'h00000099;
      tick();
      iss_valid = 1'b0; iss_we = 1'b0; wb_we = 1'b0;
      rs1_addr = 9; #1;
      check("sim_busy", 32'(rs1_busy), 32'h1);
      check("sim_data", rs1_data, 32'h00000099);
      wb(9, 32'h0000009A);
      check("sim_busy_done", 32'(rs1_busy), 32'h0);

      // Saturation on x3
      issue(3); issue(3);
      iss_rd = 3; #1;
      check("sat_ready_2", 32'(iss_ready), 32'h1);
      issue(3);
      iss_rd = 3; #1;
      check("sat_ready_x3", 32'(iss_ready), 32'h0);
      iss_rd = 4; #1;
      check("sat_ready_x4", 32'(iss_ready), 32'h1);
      issue(3);                 // blocked: counter must not wrap
      wb(3, 32'h3);
      iss_rd = 3; #1;
      check("sat_ready_after_wb", 32'(iss_ready), 32'h1);
      wb(3, 32'h33);
      rs1_addr = 3; #1;
      check("sat_busy_1left", 32'(rs1_busy), 32'h1);
      wb(3, 32'h333);
      check("sat_busy_0left", 32'(rs1_busy), 32'h0);

      // Flush with concurrent writeback to x10
      issue(2); issue(2); issue(10);
      rs1_addr = 2; rs2_addr = 10; #1;
      check("fl_busy_x2_pre", 32'(rs1_busy), 32'h1);
      check("fl_busy_x10_pre", 32'(rs2_busy), 32'h1);
      flush = 1'b1; wb_we = 1'b1; wb_rd = 10; wb_data = 32'h55;
      tick();
      flush = 1'b0; wb_we = 1'b0; #1;
      check("fl_busy_x2", 32'(rs1_busy), 32'h0);
      check("fl_busy_x10", 32'(rs2_busy), 32'h0);
      check("fl_data_x10", rs2_data, 32'h55);
      check("fl_data_x2", rs1_data, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
